// File: rtl/mdio_master_ctrl.sv
// mdio_master_ctrl: Clause-22 MDIO management master.
// Accepts one 32-bit frame from the host, derives MDC from CLK, and shifts
// the frame out MSB first. On reads it releases the line at turnaround and
// captures 16 data bits from MDIO_IN.
// Build option: define PREAMBLE_EN to send 32 MDC cycles of ones before
// each frame.
module mdio_master_ctrl #(
  parameter int MDC_DIV = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] T_DATA,
  input  logic        T_STB,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY
);

  localparam int DW = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(MDC_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRE   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic            mdc_q, mdc_d;
  logic [5:0]      bit_cnt_q, bit_cnt_d;
  logic [31:0]     frame_q, frame_d;
  logic [15:0]     sh_q, sh_d;
  logic [15:0]     rd_data_q, rd_data_d;
  logic            out_q, out_d;
  logic            oe_q, oe_d;

  logic            wrap, fall_evt, rise_evt;
  logic            op_ok, is_rd;

  // MDC edge events: a divider wrap toggles MDC, direction set by its level
  assign wrap     = (div_cnt_q == DIV_LAST);
  assign fall_evt = wrap &  mdc_q;
  assign rise_evt = wrap & ~mdc_q;
  assign op_ok    = (T_DATA[29:28] == 2'b01) || (T_DATA[29:28] == 2'b10);
  assign is_rd    = (frame_q[29:28] == 2'b10);

  // State register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: frame phases advance only on MDC falling events
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (T_STB && op_ok) begin
`ifdef PREAMBLE_EN
          state_d = S_PRE;
`else
          state_d = S_SHIFT;
`endif
        end
      end
      S_PRE: begin
        if (fall_evt && (bit_cnt_q == 6'd31)) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (fall_evt && (bit_cnt_q == 6'd32)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      mdc_q     <= 1'b0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      sh_q      <= '0;
      rd_data_q <= '0;
      out_q     <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      mdc_q     <= mdc_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      sh_q      <= sh_d;
      rd_data_q <= rd_data_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
    end
  end

  // Datapath next values: divider, launch on fall, sample on rise
  always_comb begin
    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    mdc_d     = wrap ? ~mdc_q : mdc_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    sh_d      = sh_q;
    rd_data_d = rd_data_q;
    out_d     = out_q;
    oe_d      = oe_q;
    case (state_q)
      S_IDLE: begin
        if (T_STB && op_ok) begin
          frame_d   = T_DATA;
          bit_cnt_d = '0;
        end
      end
`ifdef PREAMBLE_EN
      S_PRE: begin
        if (fall_evt) begin
          out_d     = 1'b1;
          oe_d      = 1'b1;
          bit_cnt_d = (bit_cnt_q == 6'd31) ? 6'd0 : bit_cnt_q + 6'd1;
        end
      end
`endif
      S_SHIFT: begin
        if (fall_evt) begin
          if (bit_cnt_q < 6'd32) begin
            // reads drop OE from the turnaround onward and park the line low
            oe_d      = !is_rd || (bit_cnt_q < 6'd14);
            out_d     = oe_d ? frame_q[~bit_cnt_q[4:0]] : 1'b0;
            bit_cnt_d = bit_cnt_q + 6'd1;
          end else begin
            oe_d  = 1'b0;
            out_d = 1'b0;
            if (is_rd) rd_data_d = sh_q;
          end
        end
        // counter already points past the launched bit: 17..32 => bits 16..31
        if (rise_evt && is_rd && (bit_cnt_q >= 6'd17) && (bit_cnt_q <= 6'd32))
          sh_d = {sh_q[14:0], MDIO_IN};
      end
      S_DONE: begin
        bit_cnt_d = '0;
      end
      default: ;
    endcase
  end

  // Outputs: status decoded from state, line signals straight from flops
  always_comb begin
    BUSY     = (state_q == S_PRE) || (state_q == S_SHIFT);
    DATA_RDY = (state_q == S_DONE) && is_rd;
    MDC      = mdc_q;
    MDIO_OUT = out_q;
    MDIO_OE  = oe_q;
    RD_DATA  = rd_data_q;
  end

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// tb_mdio_master_ctrl: randomized bench with a frame-level reference model.
// The model expands each accepted request into the list of (OE, OUT) values
// the line must show on successive MDC falls, plays a PHY for reads, and
// checks every output on every falling CLK edge.
module tb_mdio_master_ctrl;
  localparam int MDC_DIV = 2;
`ifdef PREAMBLE_EN
  localparam int PRE = 32;
`else
  localparam int PRE = 0;
`endif

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] T_DATA = '0;
  logic        T_STB = 1'b0;
  logic        MDIO_IN = 1'b0;
  logic        MDC, MDIO_OUT, MDIO_OE, DATA_RDY, BUSY;
  logic [15:0] RD_DATA;

  mdio_master_ctrl #(.MDC_DIV(MDC_DIV)) dut (
    .CLK(CLK), .reset(reset), .T_DATA(T_DATA), .T_STB(T_STB), .MDIO_IN(MDIO_IN),
    .MDC(MDC), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE), .RD_DATA(RD_DATA),
    .DATA_RDY(DATA_RDY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // CLK edges since reset release; MDC must equal (edges / MDC_DIV) mod 2
  int cyc;
  always @(posedge CLK or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Model state (written only by the checker process)
  bit          m_busy = 0, m_pend = 0, m_rd = 0;
  int          m_k = 0, m_len = 0;
  bit          s_oe[64], s_out[64], s_chk[64];
  logic [15:0] m_rdata = '0, m_phy = '0;
  logic [31:0] obs_word = '0;
  int          rdy_cnt = 0;
  logic [15:0] phy_val = '0;   // set by stimulus before a read

  initial begin
    bit last_oe, last_out, last_chk, prev_mdc, exp_mdc, fall, done_now;
    int fb;
    last_oe = 0; last_out = 0; last_chk = 1; prev_mdc = 0;
    forever begin
      @(negedge CLK);
      if (reset) begin
        chk("rst_mdc", MDC, 0);
        chk("rst_oe", MDIO_OE, 0);
        chk("rst_out", MDIO_OUT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_rdy", DATA_RDY, 0);
        chk("rst_rddata", RD_DATA, 0);
        m_busy = 0; m_pend = 0; m_rdata = '0;
        last_oe = 0; last_out = 0; last_chk = 1; prev_mdc = 0;
      end else begin
        exp_mdc  = ((cyc / MDC_DIV) % 2) == 1;
        fall     = prev_mdc && !exp_mdc;
        prev_mdc = exp_mdc;
        done_now = 0;
        if (fall && m_busy) begin
          if (m_k < m_len) begin
            last_oe = s_oe[m_k]; last_out = s_out[m_k]; last_chk = s_chk[m_k];
            fb = m_k - PRE;
            if (fb >= 0) obs_word[31-fb] = MDIO_OUT;
            if (m_rd && fb >= 16 && fb <= 31) MDIO_IN = m_phy[31-fb];
            else                              MDIO_IN = 1'($urandom);
            m_k++;
          end else begin
            last_oe = 0; last_out = 0; last_chk = 1;
            m_busy = 0; done_now = 1;
            if (m_rd) m_rdata = m_phy;
          end
        end
        if (m_pend) begin
          m_pend = 0; m_busy = 1; m_k = 0;
        end
        chk("mdc", MDC, 32'(exp_mdc));
        chk("oe", MDIO_OE, 32'(last_oe));
        if (last_chk) chk("out", MDIO_OUT, 32'(last_out));
        chk("busy", BUSY, 32'(m_busy));
        chk("data_rdy", DATA_RDY, 32'(done_now && m_rd));
        chk("rd_data", RD_DATA, 32'(m_rdata));
        if (DATA_RDY) rdy_cnt++;
        // request sampled at the coming edge; accepted only from idle
        if (T_STB && !m_busy && !done_now &&
            (T_DATA[29:28] == 2'b01 || T_DATA[29:28] == 2'b10)) begin
          m_pend = 1;
          m_rd   = (T_DATA[29:28] == 2'b10);
          m_phy  = phy_val;
          m_len  = PRE + 32;
          obs_word = '0;
          for (int i = 0; i < PRE; i++) begin
            s_oe[i] = 1; s_out[i] = 1; s_chk[i] = 1;
          end
          for (int b = 0; b < 32; b++) begin
            s_oe[PRE+b]  = !m_rd || (b < 14);
            s_out[PRE+b] = T_DATA[31-b];
            s_chk[PRE+b] = s_oe[PRE+b];
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] d);
    @(posedge CLK); #1;
    T_DATA = d; T_STB = 1'b1;
    @(posedge CLK); #1;
    T_STB = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while ((m_busy || m_pend) && c < 2000) begin
      @(posedge CLK); c++;
    end
    if (c >= 2000) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout waiting for frame end");
    end
  endtask

  initial begin
    int c, r0;
    logic [31:0] d;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", BUSY, 0);
    chk("async_rst_oe", MDIO_OE, 0);
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;

    // 1: write 5886BEEF
    r0 = rdy_cnt;
    send(32'h5886BEEF);
    wait_done(c);
    chk("t1_word", obs_word, 32'h5886BEEF);
    chk("t1_busy_len_ok", 32'((c >= 128*(1+PRE/32)) && (c <= 128*(1+PRE/32)+6)), 1);
    chk("t1_no_rdy", rdy_cnt - r0, 0);

    // 2: read, PHY returns A5C3
    phy_val = 16'hA5C3; r0 = rdy_cnt;
    send(32'h68860000);
    wait_done(c);
    @(posedge CLK); #1;
    chk("t2_rd_data", RD_DATA, 32'h0000A5C3);
    chk("t2_one_rdy", rdy_cnt - r0, 1);

    // 3: OP=00 dropped, then a normal write
    send(32'h40000000);
    repeat (6) @(posedge CLK);
    #1 chk("t3_busy", BUSY, 0);
    chk("t3_oe", MDIO_OE, 0);
    send(32'h5412_3456);
    wait_done(c);
    chk("t3_word", obs_word, 32'h54123456);

    // 4: second strobe mid-write is ignored
    r0 = rdy_cnt;
    send(32'h5A5AC3C3);
    repeat (60) @(posedge CLK);
    send(32'h6FFF1234);
    wait_done(c);
    chk("t4_word", obs_word, 32'h5A5AC3C3);
    repeat (6) @(posedge CLK);
    #1 chk("t4_single", BUSY, 0);
    chk("t4_no_rdy", rdy_cnt - r0, 0);

    // 5: reset at bit 20 of a read, then a clean read
    phy_val = 16'h1357; r0 = rdy_cnt;
    send(32'h68860000);
    c = 0;
    while (m_k < PRE + 21 && c < 2000) begin @(posedge CLK); c++; end
    if (c >= 2000) begin n_cmp++; n_bad++; $display("FAIL timeout reaching bit 20"); end
    #1 reset = 1'b1;
    #1;
    chk("t5_mdc", MDC, 0);
    chk("t5_oe", MDIO_OE, 0);
    chk("t5_out", MDIO_OUT, 0);
    chk("t5_busy", BUSY, 0);
    chk("t5_rddata", RD_DATA, 0);
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
    chk("t5_no_rdy", rdy_cnt - r0, 0);
    phy_val = 16'($urandom);
    send(32'h6A0A0000);
    wait_done(c);
    @(posedge CLK); #1;
    chk("t5_rd_data", RD_DATA, 32'(phy_val));

    // random mix of writes, reads, invalid ops and stray strobes
    for (int it = 0; it < 14; it++) begin
      d = {2'b01, 2'($urandom), 28'($urandom)};
      phy_val = 16'($urandom);
      send(d);
      if (d[29:28] == 2'b01 || d[29:28] == 2'b10) begin
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(5, 100)) @(posedge CLK);
          send(32'h5000_0000 | 32'($urandom));
        end
        wait_done(c);
        @(posedge CLK); #1;
        if (d[29:28] == 2'b01) chk("rnd_word", obs_word, d);
        else                   chk("rnd_rd_data", RD_DATA, 32'(phy_val));
      end else begin
        repeat (4) @(posedge CLK);
        #1 chk("rnd_drop_busy", BUSY, 0);
      end
    end

    repeat (4) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
